pic_ctrl_sync: RTL and testbench
================================

Name: pic_ctrl_sync

Overview:
- Synchronous, parametrised interrupt-controller core for the 8259-style PIC.
- Handles the full ICW1–ICW4 init sequence, OCW1–OCW3, and the edge/level IRR.
- Provides fully nested priority resolution with rotation, specific/non-specific/auto EOI, and the two-pulse INTA vector handshake.
- All bus strobes are sampled on one clock; this block replaces the strobe-edge-triggered control logic.

Parameters:
- NUM_IRQ, 8, number of request lines; legal values 2, 4, 8.
- ID_W, 3, width of the IRQ id; must equal clog2(NUM_IRQ) and is at least 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- wr_n  in  1  CPU write strobe; active-low, synchronous to clk.
- rd_n  in  1  CPU read strobe; active-low.
- a0  in  1  register select.
- din  in  8  CPU write data.
- dout  out  8  read data / vector.
- dout_en  out  1  high while dout must drive the bus.
- inta_n  in  1  interrupt acknowledge; active-low.
- irq_in  in  NUM_IRQ  request lines.
- int_out  out  1  interrupt request to CPU.
- imr  out  NUM_IRQ  mask register.
- isr  out  NUM_IRQ  in-service register.
- irr  out  NUM_IRQ  request register.
- ready  out  1  init sequence complete.

Behaviour:
- Reset values:
  - State and outputs: cfg FSM=ICW1; imr, isr, irr = 0; dout=0; dout_en=0; int_out=0; ready=0.
  - Internal registers: lowest-priority pointer lp=NUM_IRQ-1; LTIM=0; SNGL=1; IC4=0; AEOI=0; rot_aeoi=0; read select=IRR; vector base=0.
- Strobe detection: a write, read or INTA edge is a 1-cycle event, taken from the registered previous value of the strobe vs. the current value. Only one write event is decoded per falling edge of wr_n.
- ICW1 (write, a0=0, din[4]=1) is accepted in any state and takes effect the next cycle:
  - Latches IC4=din[0], SNGL=din[1], LTIM=din[3].
  - Clears imr, isr, irr and rot_aeoi; sets lp=NUM_IRQ-1 and read select=IRR.
  - Aborts any INTA sequence (int_out=0, dout_en=0); FSM goes to ICW2.
- Config FSM ICW1->ICW2->ICW3->ICW4->READY; each step consumes one write with a0=1:
  - ICW2: base=din[7:ID_W]. Next state is ICW3 if SNGL=0, else ICW4 if IC4=1, else READY.
  - ICW3: stored, no further effect. Next state is ICW4 if IC4=1, else READY.
  - ICW4: AEOI=din[1]. Next state is READY.
  - Writes with a0=0 that are not ICW1, made during ICW2–ICW4, are ignored.
- READY-state writes:
  - a0=1: OCW1, imr=din[NUM_IRQ-1:0].
  - a0=0, din[4:3]=00: OCW2, with L=din[ID_W-1:0]; see the OCW2 codes below.
  - a0=0, din[4:3]=01: OCW3. If din[1]=1, read select = din[0] ? ISR : IRR.
- OCW2 codes (din[7:5]):
  - 001 non-specific EOI: clears the highest-priority set isr bit.
  - 011 specific EOI: clears isr[L].
  - 101 rotate on non-specific EOI: clears as for 001 and sets lp to the cleared id.
  - 111 rotate on specific EOI: clears isr[L] and sets lp=L.
  - 110 set priority: lp=L.
  - 100: rot_aeoi=1.
  - 000: rot_aeoi=0.
  - 010: no-op.
  - Non-specific EOI with isr=0: no effect.
- IRR:
  - Edge mode (LTIM=0): a registered rising edge on irq_in[i] sets irr[i].
  - Level mode (LTIM=1): irr[i] follows the registered irq_in[i].
  - The INTA1 grant clears irr[id]. If a new edge on irq_in[id] arrives in the same cycle, the set wins.
- Priority:
  - Order is cyclic starting at lp+1, descending to lp.
  - The candidate is the first bit set in irr & ~imr.
  - The candidate is valid only if it has higher priority than every set isr bit (fully nested).
  - int_out is registered: 1 in READY when a valid candidate exists and no INTA sequence is in progress; otherwise 0.
- INTA handshake, 2 pulses:
  - Falling edge 1: latch id = candidate; set isr[id], clear irr[id]; int_out=0.
  - Spurious INTA1 (no candidate): id=NUM_IRQ-1 and isr is unchanged.
  - Falling edge 2: dout = {base, id}, dout_en=1 until inta_n rises.
  - Rising edge after pulse 2: if AEOI=1, clear isr[id], and if rot_aeoi=1 also set lp=id. The sequence then ends.
  - inta_n edges outside READY are ignored.
- Read: while rd_n is low and no INTA pulse 2 is active, dout_en=1.
  - a0=1: dout=imr, zero-extended to 8 bits.
  - a0=0: dout = the selected irr or isr, zero-extended to 8 bits.
  - INTA pulse 2 has precedence over a read.
- Same-cycle events: an ICW1 write overrides everything. An EOI clear and an INTA1 set on the same bit in the same cycle resolve to set.

Test Plan:
- Init: ICW1=0x13, ICW2=0x20, ICW4=0x01, OCW1=0x00. Then ready=1 after the 3rd write, which confirms the ICW3 step is skipped.
- Fixed priority: raise irq_in 0x24 with lp=7, then do the INTA pair. Required: int_out=1, vector 0x22, isr=0x04, irr=0x20. After non-specific EOI (OCW2=0x20): isr=0, int_out=1 again, and the next vector is 0x25.
- Nesting: hold isr[2], then raise irq 3 and irq 1. Irq 1 is acknowledged (vector 0x21) while irq 3 is blocked. Specific EOI 0x61 clears isr[1] only.
- Rotation: OCW2=0xC4 sets lp=4, then irq_in=0x21. Required: vector 0x25 first, then 0x20.
- AEOI + rot_aeoi: ICW4=0x03, OCW2=0x80, then ack irq 6. Required: isr=0 after the second inta_n rise, and lp=6.
- Level mode, mask, reset:
  - ICW1=0x1B with irq 3 held: irr[3] stays 1 after the ack.
  - imr=0x08 suppresses int_out.
  - OCW3=0x0B then read (a0=0) returns isr.
  - rst_n low mid-INTA clears dout_en and int_out immediately.

Source files
------------

// File: rtl/pic_ctrl_sync_if.sv
// Bus and status bundle between a CPU-side driver and the PIC core.
interface pic_ctrl_sync_if #(
  parameter int NUM_IRQ = 8
);
  logic               wr_n;
  logic               rd_n;
  logic               a0;
  logic [7:0]         din;
  logic [7:0]         dout;
  logic               dout_en;
  logic               inta_n;
  logic [NUM_IRQ-1:0] irq_in;
  logic               int_out;
  logic [NUM_IRQ-1:0] imr;
  logic [NUM_IRQ-1:0] isr;
  logic [NUM_IRQ-1:0] irr;
  logic               ready;

  modport master (
    output wr_n, rd_n, a0, din, inta_n, irq_in,
    input  dout, dout_en, int_out, imr, isr, irr, ready
  );

  modport slave (
    input  wr_n, rd_n, a0, din, inta_n, irq_in,
    output dout, dout_en, int_out, imr, isr, irr, ready
  );
endinterface

// File: rtl/pic_ctrl_sync.sv
// 8259-style interrupt controller core, fully clocked: strobes are sampled
// on clk and turned into one-cycle events from their registered previous value.
module pic_ctrl_sync #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = 3
) (
  input logic         clk,
  input logic         rst_n,
  pic_ctrl_sync_if.slave bus
);

  localparam int              BASE_W = 8 - ID_W;
  localparam logic [ID_W-1:0] ID_MAX = ID_W'(NUM_IRQ - 1);

  typedef enum logic [2:0] {CFG_ICW1, CFG_ICW2, CFG_ICW3, CFG_ICW4, CFG_READY} cfg_t;
  typedef enum logic [1:0] {IA_IDLE, IA_WAIT2, IA_PULSE2} ia_t;

  cfg_t               cfg_q, cfg_d;
  ia_t                ia_q, ia_d;
  logic               wr_q, inta_q;
  logic [NUM_IRQ-1:0] irq_q, irq_q2;
  logic [NUM_IRQ-1:0] irr_q, irr_d, isr_q, isr_d, imr_q, imr_d;
  logic [ID_W-1:0]    lp_q, lp_d, id_q, id_d;
  logic               ltim_q, ltim_d, sngl_q, sngl_d, ic4_q, ic4_d;
  logic               aeoi_q, aeoi_d, rot_aeoi_q, rot_aeoi_d, rsel_q, rsel_d;
  logic [BASE_W-1:0]  base_q, base_d;
  logic [7:0]         dout_q, dout_d;
  logic               dout_en_q, dout_en_d, int_q, int_d;

  // Walks the cyclic order lp+1 .. lp; a set bit in blk stops the search
  // (fully nested blocking), the first set bit in req is returned as {valid, id}.
  function automatic logic [ID_W:0] pick(input logic [NUM_IRQ-1:0] req,
                                         input logic [NUM_IRQ-1:0] blk,
                                         input logic [ID_W-1:0]    lp);
    logic            done;
    logic [ID_W-1:0] idx;
    logic [ID_W:0]   res;
    done = 1'b0;
    res  = '0;
    for (int k = 1; k <= NUM_IRQ; k++) begin
      idx = lp + ID_W'(k);
      if (!done) begin
        if (blk[idx]) begin
          done = 1'b1;
        end else if (req[idx]) begin
          done = 1'b1;
          res  = {1'b1, idx};
        end
      end
    end
    return res;
  endfunction

  logic               wr_ev, inta_fall, inta_rise, icw1_ev;
  logic [NUM_IRQ-1:0] irq_edge;
  logic [ID_W:0]      cand, hi;
  logic               cand_v, hi_v;
  logic [ID_W-1:0]    cand_id, hi_id, lvl;

  assign wr_ev     = wr_q & ~bus.wr_n;
  assign inta_fall = inta_q & ~bus.inta_n;
  assign inta_rise = ~inta_q & bus.inta_n;
  assign icw1_ev   = wr_ev & ~bus.a0 & bus.din[4];
  assign irq_edge  = irq_q & ~irq_q2;
  assign cand      = pick(irr_q & ~imr_q, isr_q, lp_q);
  assign hi        = pick(isr_q, '0, lp_q);
  assign cand_v    = cand[ID_W];
  assign cand_id   = cand[ID_W-1:0];
  assign hi_v      = hi[ID_W];
  assign hi_id     = hi[ID_W-1:0];
  assign lvl       = bus.din[ID_W-1:0];

  // Next-state for config FSM, INTA sequencer, registers and bus outputs.
  always_comb begin
    logic [NUM_IRQ-1:0] eoi_clr, isr_set, grant_clr;
    cfg_d      = cfg_q;
    ia_d       = ia_q;
    irr_d      = irr_q;
    isr_d      = isr_q;
    imr_d      = imr_q;
    lp_d       = lp_q;
    id_d       = id_q;
    ltim_d     = ltim_q;
    sngl_d     = sngl_q;
    ic4_d      = ic4_q;
    aeoi_d     = aeoi_q;
    rot_aeoi_d = rot_aeoi_q;
    rsel_d     = rsel_q;
    base_d     = base_q;
    dout_d     = dout_q;
    dout_en_d  = 1'b0;
    int_d      = 1'b0;
    eoi_clr    = '0;
    isr_set    = '0;
    grant_clr  = '0;

    if (icw1_ev) begin
      ic4_d      = bus.din[0];
      sngl_d     = bus.din[1];
      ltim_d     = bus.din[3];
      imr_d      = '0;
      isr_d      = '0;
      irr_d      = '0;
      rot_aeoi_d = 1'b0;
      lp_d       = ID_MAX;
      rsel_d     = 1'b0;
      ia_d       = IA_IDLE;
      cfg_d      = CFG_ICW2;
    end else begin
      case (cfg_q)
        CFG_ICW2: if (wr_ev && bus.a0) begin
          base_d = bus.din[7:ID_W];
          cfg_d  = !sngl_q ? CFG_ICW3 : (ic4_q ? CFG_ICW4 : CFG_READY);
        end
        CFG_ICW3: if (wr_ev && bus.a0) begin
          cfg_d = ic4_q ? CFG_ICW4 : CFG_READY;
        end
        CFG_ICW4: if (wr_ev && bus.a0) begin
          aeoi_d = bus.din[1];
          cfg_d  = CFG_READY;
        end
        CFG_READY: begin
          if (wr_ev && bus.a0) begin
            imr_d = bus.din[NUM_IRQ-1:0];
          end else if (wr_ev && bus.din[4:3] == 2'b00) begin
            case (bus.din[7:5])
              3'b001: if (hi_v) eoi_clr[hi_id] = 1'b1;
              3'b011: eoi_clr[lvl] = 1'b1;
              3'b101: if (hi_v) begin
                eoi_clr[hi_id] = 1'b1;
                lp_d           = hi_id;
              end
              3'b111: begin
                eoi_clr[lvl] = 1'b1;
                lp_d         = lvl;
              end
              3'b110: lp_d = lvl;
              3'b100: rot_aeoi_d = 1'b1;
              3'b000: rot_aeoi_d = 1'b0;
              default: ;
            endcase
          end else if (wr_ev && bus.din[4:3] == 2'b01 && bus.din[1]) begin
            rsel_d = bus.din[0];
          end

          case (ia_q)
            IA_IDLE: if (inta_fall) begin
              ia_d = IA_WAIT2;
              if (cand_v) begin
                id_d               = cand_id;
                isr_set[cand_id]   = 1'b1;
                grant_clr[cand_id] = 1'b1;
              end else begin
                id_d = ID_MAX;
              end
            end
            IA_WAIT2: if (inta_fall) ia_d = IA_PULSE2;
            IA_PULSE2: if (inta_rise) begin
              ia_d = IA_IDLE;
              if (aeoi_q) begin
                eoi_clr[id_q] = 1'b1;
                if (rot_aeoi_q) lp_d = id_q;
              end
            end
            default: ia_d = IA_IDLE;
          endcase
        end
        default: ;
      endcase

      // A set from INTA1 beats a same-cycle EOI clear; a new edge beats the grant clear.
      isr_d = (isr_q & ~eoi_clr) | isr_set;
      irr_d = ltim_q ? irq_q : ((irr_q & ~grant_clr) | irq_edge);

      int_d = (cfg_q == CFG_READY) && cand_v && (ia_d == IA_IDLE);
      if (ia_d == IA_PULSE2) begin
        dout_d    = {base_q, id_d};
        dout_en_d = 1'b1;
      end else if (!bus.rd_n) begin
        dout_en_d = 1'b1;
        dout_d    = bus.a0 ? 8'(imr_q) : (rsel_q ? 8'(isr_q) : 8'(irr_q));
      end
    end
  end

  // State and strobe/request history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q      <= CFG_ICW1;
      ia_q       <= IA_IDLE;
      wr_q       <= 1'b1;
      inta_q     <= 1'b1;
      irq_q      <= '0;
      irq_q2     <= '0;
      irr_q      <= '0;
      isr_q      <= '0;
      imr_q      <= '0;
      lp_q       <= ID_MAX;
      id_q       <= '0;
      ltim_q     <= 1'b0;
      sngl_q     <= 1'b1;
      ic4_q      <= 1'b0;
      aeoi_q     <= 1'b0;
      rot_aeoi_q <= 1'b0;
      rsel_q     <= 1'b0;
      base_q     <= '0;
      dout_q     <= '0;
      dout_en_q  <= 1'b0;
      int_q      <= 1'b0;
    end else begin
      cfg_q      <= cfg_d;
      ia_q       <= ia_d;
      wr_q       <= bus.wr_n;
      inta_q     <= bus.inta_n;
      irq_q      <= bus.irq_in;
      irq_q2     <= irq_q;
      irr_q      <= irr_d;
      isr_q      <= isr_d;
      imr_q      <= imr_d;
      lp_q       <= lp_d;
      id_q       <= id_d;
      ltim_q     <= ltim_d;
      sngl_q     <= sngl_d;
      ic4_q      <= ic4_d;
      aeoi_q     <= aeoi_d;
      rot_aeoi_q <= rot_aeoi_d;
      rsel_q     <= rsel_d;
      base_q     <= base_d;
      dout_q     <= dout_d;
      dout_en_q  <= dout_en_d;
      int_q      <= int_d;
    end
  end

  assign bus.dout    = dout_q;
  assign bus.dout_en = dout_en_q;
  assign bus.int_out = int_q;
  assign bus.imr     = imr_q;
  assign bus.isr     = isr_q;
  assign bus.irr     = irr_q;
  assign bus.ready   = (cfg_q == CFG_READY);

endmodule

// File: tb/tb_pic_ctrl_sync.sv
// Directed bench for pic_ctrl_sync with NUM_IRQ=8.
module tb_pic_ctrl_sync;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  pic_ctrl_sync_if #(.NUM_IRQ(8)) bus ();

  pic_ctrl_sync #(.NUM_IRQ(8), .ID_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic a, input logic [7:0] d);
    bus.a0   = a;
    bus.din  = d;
    bus.wr_n = 1'b0;
    cyc(2);
    bus.wr_n = 1'b1;
    cyc(2);
  endtask

  task automatic inta_first();
    bus.inta_n = 1'b0;
    cyc(3);
    bus.inta_n = 1'b1;
    cyc(3);
  endtask

  task automatic inta_second(output logic [7:0] vec, output logic en);
    bus.inta_n = 1'b0;
    cyc(3);
    vec = bus.dout;
    en  = bus.dout_en;
    bus.inta_n = 1'b1;
    cyc(3);
  endtask

  task automatic test_reset();
    n_chk++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", bus.ready); end
    n_chk++; if (bus.int_out !== 1'b0) begin n_fail++; $display("FAIL rst_int: got %b want 0", bus.int_out); end
    n_chk++; if (bus.dout_en !== 1'b0 || bus.dout !== 8'h00) begin n_fail++; $display("FAIL rst_dout: got en=%b %h want 0 00", bus.dout_en, bus.dout); end
    n_chk++; if ({bus.imr, bus.isr, bus.irr} !== 24'h0) begin n_fail++; $display("FAIL rst_regs: got %h want 000000", {bus.imr, bus.isr, bus.irr}); end
  endtask

  task automatic test_init();
    wr(1'b0, 8'h13);
    wr(1'b1, 8'h20);
    n_chk++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL init_ready2: got %b want 0", bus.ready); end
    wr(1'b1, 8'h01);
    n_chk++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL init_ready3: got %b want 1", bus.ready); end
    wr(1'b1, 8'h00);
    n_chk++; if (bus.imr !== 8'h00) begin n_fail++; $display("FAIL init_imr: got %h want 00", bus.imr); end
  endtask

  task automatic test_fixed_priority();
    logic [7:0] v; logic e;
    bus.irq_in = 8'h24;
    cyc(5);
    n_chk++; if (bus.int_out !== 1'b1) begin n_fail++; $display("FAIL fix_int: got %b want 1", bus.int_out); end
    inta_first();
    n_chk++; if (bus.isr !== 8'h04) begin n_fail++; $display("FAIL fix_isr: got %h want 04", bus.isr); end
    n_chk++; if (bus.irr !== 8'h20) begin n_fail++; $display("FAIL fix_irr: got %h want 20", bus.irr); end
    n_chk++; if (bus.int_out !== 1'b0) begin n_fail++; $display("FAIL fix_int_ack: got %b want 0", bus.int_out); end
    inta_second(v, e);
    n_chk++; if (v !== 8'h22) begin n_fail++; $display("FAIL fix_vec1: got %h want 22", v); end
    n_chk++; if (e !== 1'b1) begin n_fail++; $display("FAIL fix_en: got %b want 1", e); end
    n_chk++; if (bus.dout_en !== 1'b0) begin n_fail++; $display("FAIL fix_en_off: got %b want 0", bus.dout_en); end
    n_chk++; if (bus.int_out !== 1'b0) begin n_fail++; $display("FAIL fix_blocked: got %b want 0", bus.int_out); end
    wr(1'b0, 8'h20);
    cyc(2);
    n_chk++; if (bus.isr !== 8'h00) begin n_fail++; $display("FAIL fix_eoi_isr: got %h want 00", bus.isr); end
    n_chk++; if (bus.int_out !== 1'b1) begin n_fail++; $display("FAIL fix_int2: got %b want 1", bus.int_out); end
    inta_first();
    inta_second(v, e);
    n_chk++; if (v !== 8'h25) begin n_fail++; $display("FAIL fix_vec2: got %h want 25", v); end
    wr(1'b0, 8'h20);
    bus.irq_in = 8'h00;
    cyc(3);
    n_chk++; if ({bus.isr, bus.irr} !== 16'h0) begin n_fail++; $display("FAIL fix_clean: got %h want 0000", {bus.isr, bus.irr}); end
  endtask

  task automatic test_nesting();
    logic [7:0] v; logic e;
    bus.irq_in = 8'h04;
    cyc(5);
    inta_first();
    inta_second(v, e);
    n_chk++; if (v !== 8'h22) begin n_fail++; $display("FAIL nest_vec2: got %h want 22", v); end
    bus.irq_in = 8'h0E;
    cyc(5);
    n_chk++; if (bus.irr !== 8'h0A) begin n_fail++; $display("FAIL nest_irr: got %h want 0a", bus.irr); end
    n_chk++; if (bus.int_out !== 1'b1) begin n_fail++; $display("FAIL nest_int: got %b want 1", bus.int_out); end
    inta_first();
    inta_second(v, e);
    n_chk++; if (v !== 8'h21) begin n_fail++; $display("FAIL nest_vec1: got %h want 21", v); end
    n_chk++; if (bus.isr !== 8'h06 || bus.irr !== 8'h08) begin n_fail++; $display("FAIL nest_regs: got isr=%h irr=%h want 06 08", bus.isr, bus.irr); end
    n_chk++; if (bus.int_out !== 1'b0) begin n_fail++; $display("FAIL nest_block3: got %b want 0", bus.int_out); end
    wr(1'b0, 8'h61);
    n_chk++; if (bus.isr !== 8'h04) begin n_fail++; $display("FAIL nest_spec_eoi: got %h want 04", bus.isr); end
    n_chk++; if (bus.int_out !== 1'b0) begin n_fail++; $display("FAIL nest_still_blk: got %b want 0", bus.int_out); end
    wr(1'b0, 8'h20);
    cyc(2);
    n_chk++; if (bus.int_out !== 1'b1) begin n_fail++; $display("FAIL nest_int3: got %b want 1", bus.int_out); end
    inta_first();
    inta_second(v, e);
    n_chk++; if (v !== 8'h23) begin n_fail++; $display("FAIL nest_vec3: got %h want 23", v); end
    wr(1'b0, 8'h20);
    bus.irq_in = 8'h00;
    cyc(3);
    n_chk++; if (bus.isr !== 8'h00) begin n_fail++; $display("FAIL nest_clean: got %h want 00", bus.isr); end
  endtask

  task automatic test_rotation();
    logic [7:0] v; logic e;
    wr(1'b0, 8'hC4);
    bus.irq_in = 8'h21;
    cyc(5);
    inta_first();
    inta_second(v, e);
    n_chk++; if (v !== 8'h25) begin n_fail++; $display("FAIL rot_vec5: got %h want 25", v); end
    wr(1'b0, 8'h20);
    cyc(2);
    inta_first();
    inta_second(v, e);
    n_chk++; if (v !== 8'h20) begin n_fail++; $display("FAIL rot_vec0: got %h want 20", v); end
    wr(1'b0, 8'h20);
    bus.irq_in = 8'h00;
    wr(1'b0, 8'hC7);
    cyc(3);
    n_chk++; if (bus.isr !== 8'h00) begin n_fail++; $display("FAIL rot_clean: got %h want 00", bus.isr); end
  endtask

  task automatic test_aeoi_rot();
    logic [7:0] v; logic e;
    wr(1'b0, 8'h13);
    n_chk++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL aeoi_reinit: got %b want 0", bus.ready); end
    wr(1'b1, 8'h20);
    wr(1'b1, 8'h03);
    wr(1'b1, 8'h00);
    wr(1'b0, 8'h80);
    bus.irq_in = 8'h40;
    cyc(5);
    inta_first();
    n_chk++; if (bus.isr !== 8'h40) begin n_fail++; $display("FAIL aeoi_isr_set: got %h want 40", bus.isr); end
    inta_second(v, e);
    n_chk++; if (v !== 8'h26) begin n_fail++; $display("FAIL aeoi_vec6: got %h want 26", v); end
    n_chk++; if (bus.isr !== 8'h00) begin n_fail++; $display("FAIL aeoi_isr_clr: got %h want 00", bus.isr); end
    bus.irq_in = 8'h00;
    cyc(2);
    bus.irq_in = 8'h81;
    cyc(5);
    inta_first();
    inta_second(v, e);
    n_chk++; if (v !== 8'h27) begin n_fail++; $display("FAIL aeoi_lp6: got %h want 27", v); end
    inta_first();
    inta_second(v, e);
    n_chk++; if (v !== 8'h20) begin n_fail++; $display("FAIL aeoi_lp7: got %h want 20", v); end
    bus.irq_in = 8'h00;
    cyc(3);
  endtask

  task automatic test_level_mask_read();
    logic [7:0] v; logic e;
    bus.irq_in = 8'h08;
    wr(1'b0, 8'h1B);
    wr(1'b1, 8'h20);
    wr(1'b1, 8'h01);
    wr(1'b1, 8'h00);
    cyc(3);
    n_chk++; if (bus.irr !== 8'h08) begin n_fail++; $display("FAIL lvl_irr: got %h want 08", bus.irr); end
    n_chk++; if (bus.int_out !== 1'b1) begin n_fail++; $display("FAIL lvl_int: got %b want 1", bus.int_out); end
    inta_first();
    inta_second(v, e);
    n_chk++; if (v !== 8'h23) begin n_fail++; $display("FAIL lvl_vec: got %h want 23", v); end
    n_chk++; if (bus.irr !== 8'h08 || bus.isr !== 8'h08) begin n_fail++; $display("FAIL lvl_hold: got irr=%h isr=%h want 08 08", bus.irr, bus.isr); end
    wr(1'b0, 8'h20);
    cyc(2);
    n_chk++; if (bus.int_out !== 1'b1) begin n_fail++; $display("FAIL lvl_reassert: got %b want 1", bus.int_out); end
    wr(1'b1, 8'h08);
    cyc(2);
    n_chk++; if (bus.int_out !== 1'b0) begin n_fail++; $display("FAIL mask_int: got %b want 0", bus.int_out); end
    wr(1'b1, 8'h88);
    wr(1'b0, 8'h0B);
    bus.a0 = 1'b0; bus.rd_n = 1'b0;
    cyc(2);
    n_chk++; if (bus.dout_en !== 1'b1 || bus.dout !== 8'h00) begin n_fail++; $display("FAIL rd_isr: got en=%b %h want 1 00", bus.dout_en, bus.dout); end
    bus.rd_n = 1'b1;
    wr(1'b0, 8'h0A);
    bus.a0 = 1'b0; bus.rd_n = 1'b0;
    cyc(2);
    n_chk++; if (bus.dout !== 8'h08) begin n_fail++; $display("FAIL rd_irr: got %h want 08", bus.dout); end
    bus.a0 = 1'b1;
    cyc(2);
    n_chk++; if (bus.dout !== 8'h88) begin n_fail++; $display("FAIL rd_imr: got %h want 88", bus.dout); end
    bus.rd_n = 1'b1;
    cyc(2);
    n_chk++; if (bus.dout_en !== 1'b0) begin n_fail++; $display("FAIL rd_release: got %b want 0", bus.dout_en); end
  endtask

  task automatic test_reset_mid_inta();
    wr(1'b1, 8'h00);
    cyc(3);
    n_chk++; if (bus.int_out !== 1'b1) begin n_fail++; $display("FAIL mid_int: got %b want 1", bus.int_out); end
    bus.inta_n = 1'b0; cyc(3);
    bus.inta_n = 1'b1; cyc(3);
    bus.inta_n = 1'b0; cyc(3);
    n_chk++; if (bus.dout_en !== 1'b1) begin n_fail++; $display("FAIL mid_en: got %b want 1", bus.dout_en); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (bus.dout_en !== 1'b0 || bus.int_out !== 1'b0) begin n_fail++; $display("FAIL mid_rst: got en=%b int=%b want 0 0", bus.dout_en, bus.int_out); end
    n_chk++; if (bus.ready !== 1'b0 || bus.isr !== 8'h00 || bus.dout !== 8'h00) begin n_fail++; $display("FAIL mid_rst_regs: got rdy=%b isr=%h dout=%h want 0 00 00", bus.ready, bus.isr, bus.dout); end
    bus.inta_n = 1'b1;
    bus.irq_in = 8'h00;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
  endtask

  initial begin
    bus.wr_n   = 1'b1;
    bus.rd_n   = 1'b1;
    bus.inta_n = 1'b1;
    bus.a0     = 1'b0;
    bus.din    = 8'h00;
    bus.irq_in = 8'h00;
    cyc(3);
    test_reset();
    rst_n = 1'b1;
    cyc(2);
    test_reset();
    test_init();
    test_fixed_priority();
    test_nesting();
    test_rotation();
    test_aeoi_rot();
    test_level_mask_read();
    test_reset_mid_inta();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
